vect_seq: RTL

Parametrised velocity-vector sequencer for the Pong ball path. It holds NCH independent tables of DEPTH signed VW-bit vector entries, one table per axis/channel. It steps all channels through their tables either on a programmable timer tick or on an external event such as a paddle hit, and drives the registered vectors to the ball-motion logic. Tables reset to package defaults and, optionally, are rewritable at run time.

---
 rtl/vect_seq_pkg.sv | 18 +
 rtl/vect_seq_div.sv | 37 +++
 rtl/vect_seq.sv | 93 +++++++++
 3 files changed

// File: rtl/vect_seq_pkg.sv
// rtl/vect_seq_pkg.sv - default vector tables, mode constants and table lookup for vect_seq
package vect_seq_pkg;

    localparam logic MODE_TIMED = 1'b0;
    localparam logic MODE_EVENT = 1'b1;

    localparam int VECT_DEFAULT_LEN = 7;
    localparam int VECT_DEFAULT_X [VECT_DEFAULT_LEN] = '{-1, -2, -3, 2, 1, 2, 3};
    localparam int VECT_DEFAULT_Y [VECT_DEFAULT_LEN] = '{1, 2, 3, -2, -1, -2, -3};

    // Channel 1 is Y; every other channel reuses X. Deep tables repeat the 7-entry pattern.
    function automatic int vect_default(input int ch, input int idx);
        int i;
        i = idx % VECT_DEFAULT_LEN;
        return (ch == 1) ? VECT_DEFAULT_Y[i] : VECT_DEFAULT_X[i];
    endfunction

endpackage

// File: rtl/vect_seq_div.sv
// rtl/vect_seq_div.sv - TICK_DIV timer tick generator with enable and synchronous clear
module vect_seq_div #(
    parameter int TICK_DIV = 8388608
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                tick_o = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vect_seq.sv
// rtl/vect_seq.sv - velocity-vector sequencer; VECT_SEQ_LOAD_EN makes the tables writable
module vect_seq
    import vect_seq_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int VW       = 3,
    parameter int DEPTH    = 7,
    parameter int TICK_DIV = 8388608,
    localparam int IW      = $clog2(DEPTH),
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              advance,
    input  logic              restart,
`ifdef VECT_SEQ_LOAD_EN
    input  logic              wr_en,
    input  logic [CHW-1:0]    wr_ch,
    input  logic [IW-1:0]     wr_addr,
    input  logic [VW-1:0]     wr_data,
`endif
    output logic [NCH*VW-1:0] vect_out,
    output logic              step_o,
    output logic [IW-1:0]     idx_o
);

    logic [VW-1:0]     tbl [NCH][DEPTH];
    logic              tick, step_req, load;
    logic [IW-1:0]     idx_q, idx_d, idx_nxt, sel_idx;
    logic [NCH*VW-1:0] vect_q, vect_d;
    logic              step_q, step_d;

    vect_seq_div #(.TICK_DIV(TICK_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .en_i   (mode == MODE_TIMED),
        .clr_i  (mode == MODE_EVENT),
        .tick_o (tick)
    );

`ifdef VECT_SEQ_LOAD_EN
    // Reads see the pre-write value, so a step and a write to one entry load the old data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++)
                for (int d = 0; d < DEPTH; d++)
                    tbl[c][d] <= VW'(vect_default(c, d));
        end else if (wr_en && (32'(wr_ch) < NCH) && (32'(wr_addr) < DEPTH)) begin
            tbl[wr_ch][wr_addr] <= wr_data;
        end
    end
`else
    always_comb begin
        for (int c = 0; c < NCH; c++)
            for (int d = 0; d < DEPTH; d++)
                tbl[c][d] = VW'(vect_default(c, d));
    end
`endif

    always_comb begin
        idx_nxt  = (idx_q == IW'(DEPTH - 1)) ? '0 : idx_q + 1'b1;
        step_req = (mode == MODE_EVENT) ? advance : tick;
        load     = restart | step_req;
        sel_idx  = restart ? '0 : idx_nxt;
        idx_d    = idx_q;
        vect_d   = vect_q;
        step_d   = 1'b0;
        if (load) begin
            idx_d  = sel_idx;
            step_d = 1'b1;
            for (int c = 0; c < NCH; c++)
                vect_d[c*VW +: VW] = tbl[c][sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q  <= '0;
            vect_q <= '0;
            step_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            vect_q <= vect_d;
            step_q <= step_d;
        end
    end

    assign vect_out = vect_q;
    assign step_o   = step_q;
    assign idx_o    = idx_q;

endmodule
